mmio_responder: RTL

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder_pkg.sv | 28 ++
 rtl/mmio_counter.sv | 34 +++
 rtl/mmio_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared MMIO address map and status layout for the responder and the X/M-stage decode.
// Optional branch counters are enabled with MMIO_BR_COUNTERS_EN.
package mmio_responder_pkg;

    localparam logic [31:0] MMIO_STATUS_ADDR    = 32'h8000_0000;
    localparam logic [31:0] MMIO_RX_DATA_ADDR   = 32'h8000_0004;
    localparam logic [31:0] MMIO_TX_DATA_ADDR   = 32'h8000_0008;
    localparam logic [31:0] MMIO_CYCLE_ADDR     = 32'h8000_0010;
    localparam logic [31:0] MMIO_INSTR_ADDR     = 32'h8000_0014;
    localparam logic [31:0] MMIO_CNT_RESET_ADDR = 32'h8000_0018;
    localparam logic [31:0] MMIO_BR_RETIRE_ADDR = 32'h8000_001C;
    localparam logic [31:0] MMIO_BR_TAKEN_ADDR  = 32'h8000_0020;

    // Status word layout
    localparam int unsigned STATUS_TX_EMPTY_BIT = 0;
    localparam int unsigned STATUS_RX_FULL_BIT  = 1;

    typedef enum logic [2:0] {
        SelNone,
        SelStatus,
        SelRxData,
        SelCycle,
        SelInstr,
        SelBrRetire,
        SelBrTaken
    } rd_sel_e;

endpackage

// File: rtl/mmio_counter.sv
// Free-running W_SIZE-bit event counter; clear takes priority over increment.
module mmio_counter #(
    parameter int unsigned W_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [W_SIZE-1:0] count
);

    logic [W_SIZE-1:0] count_q;
    logic [W_SIZE-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: UART TX/RX holding slots, performance counters and registered read data.
// Define MMIO_BR_COUNTERS_EN to add branch-retired / branch-taken counters.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int unsigned W_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_SIZE-1:0] addr,
    input  logic [W_SIZE-1:0] wdata,
    input  logic              uart_write_valid,
    input  logic              uart_ready_to_receive,
    input  logic              reset_counters,
    input  logic              inst_retire,
`ifdef MMIO_BR_COUNTERS_EN
    input  logic              br_retire,
    input  logic              br_taken,
`endif
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [W_SIZE-1:0] rdata
);

    logic              tx_full_q, tx_full_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              rx_full_q, rx_full_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [W_SIZE-1:0] rdata_q, rdata_d;
    logic              tx_pop, tx_push, rx_push;
    rd_sel_e           rd_sel;

    logic [W_SIZE-1:0] cycle_cnt;
    logic [W_SIZE-1:0] instr_cnt;

    logic unused_wdata;
    assign unused_wdata = ^wdata[W_SIZE-1:8];

    // TX slot: a pop in the same cycle as a store leaves the store dropped since the slot is full.
    assign tx_pop  = tx_full_q & tx_ready;
    assign tx_push = uart_write_valid & ~tx_full_q;

    always_comb begin
        tx_full_d = tx_full_q;
        tx_data_d = tx_data_q;
        if (tx_pop) begin
            tx_full_d = 1'b0;
        end else if (tx_push) begin
            tx_full_d = 1'b1;
            tx_data_d = wdata[7:0];
        end
    end

    // RX slot: an incoming byte into an empty slot wins over a concurrent load.
    assign rx_push = rx_valid & ~rx_full_q;

    always_comb begin
        rx_full_d = rx_full_q;
        rx_data_d = rx_data_q;
        if (uart_ready_to_receive) begin
            rx_full_d = 1'b0;
        end
        if (rx_push) begin
            rx_full_d = 1'b1;
            rx_data_d = rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_full_q <= 1'b0;
            tx_data_q <= 8'h00;
            rx_full_q <= 1'b0;
            rx_data_q <= 8'h00;
        end else begin
            tx_full_q <= tx_full_d;
            tx_data_q <= tx_data_d;
            rx_full_q <= rx_full_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign tx_valid = tx_full_q;
    assign tx_data  = tx_data_q;
    assign rx_ready = ~rx_full_q;

    mmio_counter #(
        .W_SIZE (W_SIZE)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (reset_counters),
        .inc   (1'b1),
        .count (cycle_cnt)
    );

    mmio_counter #(
        .W_SIZE (W_SIZE)
    ) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (reset_counters),
        .inc   (inst_retire),
        .count (instr_cnt)
    );

`ifdef MMIO_BR_COUNTERS_EN
    logic [W_SIZE-1:0] br_retire_cnt;
    logic [W_SIZE-1:0] br_taken_cnt;

    mmio_counter #(
        .W_SIZE (W_SIZE)
    ) u_br_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (reset_counters),
        .inc   (br_retire),
        .count (br_retire_cnt)
    );

    mmio_counter #(
        .W_SIZE (W_SIZE)
    ) u_br_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (reset_counters),
        .inc   (br_taken),
        .count (br_taken_cnt)
    );
`endif

    always_comb begin
        rd_sel = SelNone;
        if (addr == W_SIZE'(MMIO_STATUS_ADDR)) begin
            rd_sel = SelStatus;
        end else if (addr == W_SIZE'(MMIO_RX_DATA_ADDR)) begin
            rd_sel = SelRxData;
        end else if (addr == W_SIZE'(MMIO_CYCLE_ADDR)) begin
            rd_sel = SelCycle;
        end else if (addr == W_SIZE'(MMIO_INSTR_ADDR)) begin
            rd_sel = SelInstr;
`ifdef MMIO_BR_COUNTERS_EN
        end else if (addr == W_SIZE'(MMIO_BR_RETIRE_ADDR)) begin
            rd_sel = SelBrRetire;
        end else if (addr == W_SIZE'(MMIO_BR_TAKEN_ADDR)) begin
            rd_sel = SelBrTaken;
`endif
        end
    end

    // Counters are sampled before this cycle's update.
    always_comb begin
        rdata_d = '0;
        case (rd_sel)
            SelStatus: begin
                rdata_d[STATUS_RX_FULL_BIT]  = rx_full_q;
                rdata_d[STATUS_TX_EMPTY_BIT] = ~tx_full_q;
            end
            SelRxData: rdata_d[7:0] = rx_data_q;
            SelCycle:  rdata_d = cycle_cnt;
            SelInstr:  rdata_d = instr_cnt;
`ifdef MMIO_BR_COUNTERS_EN
            SelBrRetire: rdata_d = br_retire_cnt;
            SelBrTaken:  rdata_d = br_taken_cnt;
`endif
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
